// File: rtl/cpc_bus_pkg.sv
// Shared constants and state encoding for the CPC bus cycle tracker.
package cpc_bus_pkg;

  localparam logic [2:0] CYC_IDLE  = 3'd0;
  localparam logic [2:0] CYC_FETCH = 3'd1;
  localparam logic [2:0] CYC_MRD   = 3'd2;
  localparam logic [2:0] CYC_MPEND = 3'd3;
  localparam logic [2:0] CYC_MWR   = 3'd4;
  localparam logic [2:0] CYC_RFSH  = 3'd5;
  localparam logic [2:0] CYC_IOR   = 3'd6;
  localparam logic [2:0] CYC_IOW   = 3'd7;

  localparam logic [1:0] BANK_CMD_MASK = 2'b11;
  localparam logic       PORT_7F       = 1'b1;
  localparam logic       PORT_7E       = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MRD,
    S_MPEND,
    S_MWR,
    S_RFSH,
    S_IO,
    S_IOW,
    S_INTACK
  } cyc_state_e;

  // Interrupt acknowledge is reported as an I/O read cycle.
  function automatic logic [2:0] cyc_code(input cyc_state_e s);
    case (s)
      S_FETCH:        return CYC_FETCH;
      S_MRD:          return CYC_MRD;
      S_MPEND:        return CYC_MPEND;
      S_MWR:          return CYC_MWR;
      S_RFSH:         return CYC_RFSH;
      S_IO, S_INTACK: return CYC_IOR;
      S_IOW:          return CYC_IOW;
      default:        return CYC_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cpc_bus_cycle_tracker_if.sv
// Raw Z80/CPC bus signals as seen by the expansion CPLD.
interface cpc_bus_cycle_tracker_if;
  logic       mreq_b;
  logic       iorq_b;
  logic       rd_b;
  logic       wr_b;
  logic       m1_b;
  logic       rfsh_b;
  logic       adr15;
  logic       adr8;
  logic [7:0] data;

  modport master (
    output mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr8, data
  );

  modport slave (
    input mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr8, data
  );
endinterface

// File: rtl/cpc_cyc_counter.sv
// Saturating machine-cycle length counter with load-to-one, clear and capture.
module cpc_cyc_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             inc,
  input  logic             capture,
  output logic [LEN_W-1:0] len
);

  logic [LEN_W-1:0] cnt;

  // Capture sees the pre-update count, so a cycle ending and the next one
  // starting on the same clk report and restart correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      len <= '0;
    end else begin
      if (capture) len <= cnt;
      if (load)
        cnt <= LEN_W'(1);
      else if (clear)
        cnt <= '0;
      else if (inc && (cnt != '1))
        cnt <= cnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/cpc_bus_cycle_tracker.sv
// Classifies Z80 machine cycles, emits registered phase strobes, decodes the
// bank-select port write and flags bus protocol violations.
module cpc_bus_cycle_tracker
  import cpc_bus_pkg::*;
#(
  parameter int   LEN_W    = 4,
  parameter logic SEL_ADR8 = PORT_7F
) (
  input  logic                   clk,
  input  logic                   reset,
  cpc_bus_cycle_tracker_if.slave bus,
  output logic [2:0]             cyc_type,
  output logic                   mwr_active,
  output logic                   mwr_first,
  output logic                   cyc_end,
  output logic [LEN_W-1:0]       cyc_len,
  output logic                   bank_wr,
  output logic [5:0]             bank_q,
  output logic                   bank_sel_q,
  output logic                   bus_err
);

  cyc_state_e state;
  cyc_state_e nxt;
  cyc_state_e idle_nxt;

  logic mreq_q;
  logic iorq_q;
  logic live;
  logic fall_m;
  logic fall_i;
  logic end_cyc;
  logic start_cyc;
  logic cmd_ok;
  logic bank_hit;
  logic bank_miss8;
  logic proto_err;

  // live blocks the first clk after reset so a request already low at
  // release is never mistaken for a fresh falling edge.
  assign fall_m = live && mreq_q && !bus.mreq_b;
  assign fall_i = live && iorq_q && !bus.iorq_b;

  assign cmd_ok = !bus.adr15 && (bus.data[7:6] == BANK_CMD_MASK);

  assign proto_err = (!bus.mreq_b && !bus.iorq_b) ||
                     (!bus.rd_b && !bus.wr_b) ||
                     (!bus.wr_b && ((state == S_FETCH) || (state == S_RFSH)));

  always_comb begin
    idle_nxt = S_IDLE;
    if (fall_m) begin
      if (!bus.rfsh_b)
        idle_nxt = S_RFSH;
      else if (!bus.m1_b)
        idle_nxt = S_FETCH;
      else if (!bus.rd_b)
        idle_nxt = S_MRD;
      else
        idle_nxt = S_MPEND;
    end else if (fall_i) begin
      idle_nxt = bus.m1_b ? S_IO : S_INTACK;
    end
  end

  always_comb begin
    nxt        = state;
    end_cyc    = 1'b0;
    bank_hit   = 1'b0;
    bank_miss8 = 1'b0;
    case (state)
      S_IDLE: nxt = idle_nxt;
      S_FETCH, S_MRD, S_MWR, S_RFSH: begin
        if (bus.mreq_b) begin
          end_cyc = 1'b1;
          nxt     = idle_nxt;
        end
      end
      S_MPEND: begin
        if (bus.mreq_b) begin
          end_cyc = 1'b1;
          nxt     = idle_nxt;
        end else if (!bus.wr_b) begin
          nxt = S_MWR;
        end else if (!bus.rd_b) begin
          nxt = S_MRD;
        end
      end
      S_IO: begin
        if (bus.iorq_b) begin
          end_cyc = 1'b1;
          nxt     = idle_nxt;
        end else if (!bus.wr_b) begin
          nxt        = S_IOW;
          bank_hit   = cmd_ok && (bus.adr8 == SEL_ADR8);
          bank_miss8 = cmd_ok && (bus.adr8 != SEL_ADR8);
        end
      end
      S_IOW, S_INTACK: begin
        if (bus.iorq_b) begin
          end_cyc = 1'b1;
          nxt     = idle_nxt;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign start_cyc = (nxt != S_IDLE) && ((state == S_IDLE) || end_cyc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      live       <= 1'b0;
      cyc_type   <= CYC_IDLE;
      mwr_active <= 1'b0;
      mwr_first  <= 1'b0;
      cyc_end    <= 1'b0;
      bank_wr    <= 1'b0;
      bank_q     <= '0;
      bank_sel_q <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      mreq_q     <= bus.mreq_b;
      iorq_q     <= bus.iorq_b;
      live       <= 1'b1;
      cyc_type   <= cyc_code(nxt);
      mwr_active <= (nxt == S_MWR);
      mwr_first  <= (nxt == S_MWR) && (state != S_MWR);
      cyc_end    <= end_cyc;
      bank_wr    <= bank_hit;
      if (bank_hit) begin
        bank_q     <= bus.data[5:0];
        bank_sel_q <= 1'b1;
      end else if (bank_miss8) begin
        bank_sel_q <= 1'b0;
      end
      if (proto_err) bus_err <= 1'b1;
    end
  end

  cpc_cyc_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .clk     (clk),
    .reset   (reset),
    .load    (start_cyc),
    .clear   (end_cyc && (nxt == S_IDLE)),
    .inc     (state != S_IDLE),
    .capture (end_cyc),
    .len     (cyc_len)
  );

endmodule

// File: tb/tb_cpc_bus_cycle_tracker.sv
// Scoreboard bench for cpc_bus_cycle_tracker.
module tb_cpc_bus_cycle_tracker;
  import cpc_bus_pkg::*;

  localparam int LEN_W   = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  typedef struct packed {
    logic [5:0] q;
    logic       sel;
  } bank_exp_t;

  logic             clk;
  logic             reset;
  logic [2:0]       cyc_type;
  logic             mwr_active;
  logic             mwr_first;
  logic             cyc_end;
  logic [LEN_W-1:0] cyc_len;
  logic             bank_wr;
  logic [5:0]       bank_q;
  logic             bank_sel_q;
  logic             bus_err;

  int checks   = 0;
  int failures = 0;

  int        len_q[$];
  bank_exp_t bank_sb[$];
  int        exp_len_m;
  bank_exp_t exp_bank_m;

  cpc_bus_cycle_tracker_if bus ();

  cpc_bus_cycle_tracker #(
    .LEN_W    (LEN_W),
    .SEL_ADR8 (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cyc_type   (cyc_type),
    .mwr_active (mwr_active),
    .mwr_first  (mwr_first),
    .cyc_end    (cyc_end),
    .cyc_len    (cyc_len),
    .bank_wr    (bank_wr),
    .bank_q     (bank_q),
    .bank_sel_q (bank_sel_q),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.mreq_b = 1'b1;
    bus.iorq_b = 1'b1;
    bus.rd_b   = 1'b1;
    bus.wr_b   = 1'b1;
    bus.m1_b   = 1'b1;
    bus.rfsh_b = 1'b1;
    bus.adr15  = 1'b0;
    bus.adr8   = 1'b0;
    bus.data   = 8'h00;
  endtask

  task automatic simple_cycle(input string tag, input bit io, input bit m1, input bit rd,
                              input bit rf, input int n, input int exp_type);
    len_q.push_back((n > LEN_MAX) ? LEN_MAX : n);
    if (io) bus.iorq_b = 1'b0;
    else    bus.mreq_b = 1'b0;
    bus.m1_b   = ~m1;
    bus.rd_b   = ~rd;
    bus.rfsh_b = ~rf;
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_type"}, 32'(cyc_type), exp_type);
    end
    bus_idle();
    step();
    chk({tag, "_end"}, 32'(cyc_end), 1);
    chk({tag, "_idle"}, 32'(cyc_type), 32'(CYC_IDLE));
    step();
    chk({tag, "_endpulse"}, 32'(cyc_end), 0);
  endtask

  task automatic io_write(input string tag, input bit a15, input bit a8, input logic [7:0] d,
                          input bit hit, input logic [5:0] exp_q, input bit exp_sel);
    len_q.push_back(4);
    bus.iorq_b = 1'b0;
    bus.adr15  = a15;
    bus.adr8   = a8;
    bus.data   = d;
    step();
    chk({tag, "_io"}, 32'(cyc_type), 32'(CYC_IOR));
    bus.wr_b = 1'b0;
    if (hit) bank_sb.push_back('{q: exp_q, sel: exp_sel});
    step();
    chk({tag, "_iow"}, 32'(cyc_type), 32'(CYC_IOW));
    chk({tag, "_bank_wr"}, 32'(bank_wr), 32'(hit));
    chk({tag, "_bank_q"}, 32'(bank_q), 32'(exp_q));
    chk({tag, "_bank_sel"}, 32'(bank_sel_q), 32'(exp_sel));
    bus.wr_b = 1'b1;
    step();
    chk({tag, "_nopulse1"}, 32'(bank_wr), 0);
    bus.wr_b = 1'b0;
    step();
    chk({tag, "_nopulse2"}, 32'(bank_wr), 0);
    bus_idle();
    step();
    chk({tag, "_end"}, 32'(cyc_end), 1);
    chk({tag, "_q_hold"}, 32'(bank_q), 32'(exp_q));
  endtask

  // Scoreboard side: outputs popped against expectations as the DUT emits them.
  always @(negedge clk) begin
    if (!reset) begin
      if (cyc_end) begin
        if (len_q.size() == 0) begin
          chk("unexp_cyc_end", 32'(cyc_end), 0);
        end else begin
          exp_len_m = len_q.pop_front();
          chk("sb_cyc_len", 32'(cyc_len), exp_len_m);
        end
      end
      if (bank_wr) begin
        if (bank_sb.size() == 0) begin
          chk("unexp_bank_wr", 32'(bank_wr), 0);
        end else begin
          exp_bank_m = bank_sb.pop_front();
          chk("sb_bank_q", 32'(bank_q), 32'(exp_bank_m.q));
          chk("sb_bank_sel", 32'(bank_sel_q), 32'(exp_bank_m.sel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc_type", 32'(cyc_type), 0);
    chk("rst_mwr_active", 32'(mwr_active), 0);
    chk("rst_mwr_first", 32'(mwr_first), 0);
    chk("rst_cyc_end", 32'(cyc_end), 0);
    chk("rst_cyc_len", 32'(cyc_len), 0);
    chk("rst_bank_wr", 32'(bank_wr), 0);
    chk("rst_bank_q", 32'(bank_q), 0);
    chk("rst_bank_sel", 32'(bank_sel_q), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    #2 reset = 1'b0;
    step();

    simple_cycle("fetch", 1'b0, 1'b1, 1'b1, 1'b0, 3, 32'(CYC_FETCH));
    chk("fetch_len", 32'(cyc_len), 3);

    // Memory write: MPEND for one clk, then MWR with a single mwr_first.
    len_q.push_back(4);
    bus.mreq_b = 1'b0;
    step();
    chk("mw_pend", 32'(cyc_type), 32'(CYC_MPEND));
    chk("mw_first0", 32'(mwr_first), 0);
    chk("mw_active0", 32'(mwr_active), 0);
    bus.wr_b = 1'b0;
    step();
    chk("mw_type1", 32'(cyc_type), 32'(CYC_MWR));
    chk("mw_first1", 32'(mwr_first), 1);
    chk("mw_active1", 32'(mwr_active), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mw_type_n", 32'(cyc_type), 32'(CYC_MWR));
      chk("mw_first_n", 32'(mwr_first), 0);
    end
    bus_idle();
    step();
    chk("mw_end", 32'(cyc_end), 1);
    chk("mw_active_end", 32'(mwr_active), 0);
    chk("mw_len", 32'(cyc_len), 4);

    simple_cycle("mrd", 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'(CYC_MRD));
    simple_cycle("intack", 1'b1, 1'b1, 1'b0, 1'b0, 2, 32'(CYC_IOR));

    io_write("bank_hit", 1'b0, 1'b1, 8'hC5, 1'b1, 6'h05, 1'b1);
    io_write("bank_cmd_miss", 1'b0, 1'b1, 8'h8F, 1'b0, 6'h05, 1'b1);
    io_write("bank_a8_miss", 1'b0, 1'b0, 8'hC9, 1'b0, 6'h05, 1'b0);
    io_write("bank_a15_miss", 1'b1, 1'b1, 8'hFF, 1'b0, 6'h05, 1'b0);
    io_write("bank_hit2", 1'b0, 1'b1, 8'hFF, 1'b1, 6'h3F, 1'b1);

    // Back-to-back: each cycle ends on the clk the next request falls.
    len_q.push_back(2);
    bus.mreq_b = 1'b0;
    bus.rfsh_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("b2b_rfsh", 32'(cyc_type), 32'(CYC_RFSH));
    end
    len_q.push_back(3);
    bus.mreq_b = 1'b1;
    bus.rfsh_b = 1'b1;
    bus.iorq_b = 1'b0;
    step();
    chk("b2b_io", 32'(cyc_type), 32'(CYC_IOR));
    chk("b2b_end1", 32'(cyc_end), 1);
    step();
    chk("b2b_io2", 32'(cyc_type), 32'(CYC_IOR));
    chk("b2b_end1_once", 32'(cyc_end), 0);
    step();
    len_q.push_back(2);
    bus.iorq_b = 1'b1;
    bus.mreq_b = 1'b0;
    bus.m1_b   = 1'b0;
    step();
    chk("b2b_fetch", 32'(cyc_type), 32'(CYC_FETCH));
    chk("b2b_end2", 32'(cyc_end), 1);
    step();
    chk("b2b_end2_once", 32'(cyc_end), 0);
    bus_idle();
    step();
    chk("b2b_end3", 32'(cyc_end), 1);
    step();

    simple_cycle("sat", 1'b0, 1'b1, 1'b0, 1'b0, 20, 32'(CYC_FETCH));
    chk("sat_len", 32'(cyc_len), LEN_MAX);

    // Simultaneous MREQ/IORQ: error flagged, memory side wins.
    chk("err_clear", 32'(bus_err), 0);
    len_q.push_back(2);
    bus.mreq_b = 1'b0;
    bus.iorq_b = 1'b0;
    step();
    chk("err_mpend", 32'(cyc_type), 32'(CYC_MPEND));
    chk("err_set", 32'(bus_err), 1);
    step();
    bus_idle();
    step();
    chk("err_end", 32'(cyc_end), 1);
    simple_cycle("post_err", 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'(CYC_MRD));
    chk("err_sticky", 32'(bus_err), 1);

    // Reset in the middle of a write with MREQ held low through release.
    bus.mreq_b = 1'b0;
    step();
    bus.wr_b = 1'b0;
    step();
    chk("rmw_type", 32'(cyc_type), 32'(CYC_MWR));
    chk("rmw_first", 32'(mwr_first), 1);
    #2 reset = 1'b1;
    bus.wr_b = 1'b1;
    #1;
    chk("rmw_async_type", 32'(cyc_type), 0);
    chk("rmw_async_active", 32'(mwr_active), 0);
    chk("rmw_async_first", 32'(mwr_first), 0);
    chk("rmw_async_err", 32'(bus_err), 0);
    chk("rmw_async_bank", 32'(bank_q), 0);
    chk("rmw_async_len", 32'(cyc_len), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rmw_held_idle", 32'(cyc_type), 0);
      chk("rmw_held_end", 32'(cyc_end), 0);
    end
    bus.mreq_b = 1'b1;
    step();
    chk("rmw_rise_idle", 32'(cyc_type), 0);
    simple_cycle("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2, 32'(CYC_FETCH));

    // WR during a fetch is a protocol error.
    len_q.push_back(2);
    bus.mreq_b = 1'b0;
    bus.m1_b   = 1'b0;
    step();
    chk("fw_err_before", 32'(bus_err), 0);
    bus.wr_b = 1'b0;
    step();
    chk("fw_err", 32'(bus_err), 1);
    bus_idle();
    step();
    chk("fw_end", 32'(cyc_end), 1);

    repeat (2) step();
    chk("len_sb_drained", 32'(len_q.size()), 0);
    chk("bank_sb_drained", 32'(bank_sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
